// File: rtl/bcd_to_bin_converter.sv
// Sequential BCD-to-binary converter, one digit per clock, MSD first.
// Ports: clk, rst_n, start, bcd_in -> busy, done (pulse), bin_out, err.
module bcd_to_bin_converter #(
   parameter int DIGITS = 4,
   parameter int BIN_W  = 14
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  start,
   input  logic [4*DIGITS-1:0]   bcd_in,
   output logic                  busy,
   output logic                  done,
   output logic [BIN_W-1:0]      bin_out,
   output logic                  err
);

   localparam int SW = 4 * DIGITS;
   localparam int CW = (DIGITS > 1) ? $clog2(DIGITS) : 1;

   typedef enum logic {
      IDLE,
      CONV
   } state_e;

   state_e            state_q, state_d;
   logic [SW-1:0]     sh_q, sh_d;
   logic [BIN_W-1:0]  acc_q, acc_d;
   logic [CW-1:0]     cnt_q, cnt_d;
   logic              err_acc_q, err_acc_d;
   logic              busy_q, busy_d;
   logic              done_q, done_d;
   logic [BIN_W-1:0]  bin_q, bin_d;
   logic              err_q, err_d;

   logic [3:0]        digit;
   logic [BIN_W-1:0]  acc_nxt;
   logic              err_nxt;

   always_comb begin
      digit     = sh_q[SW-1 -: 4];
      // acc*10 as two shifts and an add; wraps mod 2^BIN_W
      acc_nxt   = (acc_q << 3) + (acc_q << 1) + BIN_W'(digit);
      err_nxt   = err_acc_q | (digit > 4'd9);

      state_d   = state_q;
      sh_d      = sh_q;
      acc_d     = acc_q;
      cnt_d     = cnt_q;
      err_acc_d = err_acc_q;
      busy_d    = busy_q;
      done_d    = 1'b0;
      bin_d     = bin_q;
      err_d     = err_q;

      unique case (state_q)
         IDLE: begin
            if (start) begin
               sh_d      = bcd_in;
               acc_d     = '0;
               cnt_d     = '0;
               err_acc_d = 1'b0;
               busy_d    = 1'b1;
               state_d   = CONV;
            end
         end
         CONV: begin
            acc_d     = acc_nxt;
            err_acc_d = err_nxt;
            sh_d      = sh_q << 4;
            cnt_d     = cnt_q + 1'b1;
            if (cnt_q == CW'(DIGITS - 1)) begin
               bin_d   = acc_nxt;
               err_d   = err_nxt;
               done_d  = 1'b1;
               busy_d  = 1'b0;
               cnt_d   = '0;
               state_d = IDLE;
            end
         end
         default: begin
            state_d = IDLE;
            busy_d  = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= IDLE;
         sh_q      <= '0;
         acc_q     <= '0;
         cnt_q     <= '0;
         err_acc_q <= 1'b0;
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
         bin_q     <= '0;
         err_q     <= 1'b0;
      end else begin
         state_q   <= state_d;
         sh_q      <= sh_d;
         acc_q     <= acc_d;
         cnt_q     <= cnt_d;
         err_acc_q <= err_acc_d;
         busy_q    <= busy_d;
         done_q    <= done_d;
         bin_q     <= bin_d;
         err_q     <= err_d;
      end
   end

   assign busy    = busy_q;
   assign done    = done_q;
   assign bin_out = bin_q;
   assign err     = err_q;

endmodule

// File: tb/tb_bcd_to_bin_converter.sv
// Scoreboard bench for bcd_to_bin_converter (DIGITS=4, BIN_W=14).
// Stimulus pushes expected results; a negedge monitor pops on done.
module tb_bcd_to_bin_converter;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        start = 1'b0;
   logic [15:0] bcd_in = '0;
   logic        busy;
   logic        done;
   logic [13:0] bin_out;
   logic        err;

   int tests = 0;
   int fails = 0;
   int cyc = 0;
   int done_cnt = 0;
   int last_done_cyc = 0;
   int prev_done_cyc = 0;

   typedef struct packed {
      logic [13:0] bin;
      logic        err;
   } exp_t;

   exp_t sb[$];

   bcd_to_bin_converter #(.DIGITS(4), .BIN_W(14)) dut (
      .clk     (clk),
      .rst_n   (rst_n),
      .start   (start),
      .bcd_in  (bcd_in),
      .busy    (busy),
      .done    (done),
      .bin_out (bin_out),
      .err     (err)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input int act, input int exp);
      tests++;
      if (act != exp) begin
         fails++;
         $display("FAIL %s: got %0d, expected %0d", name, act, exp);
      end
   endtask

   // Monitor: every done must match the oldest expectation.
   always @(negedge clk) begin
      if (rst_n && done) begin
         exp_t e;
         done_cnt      = done_cnt + 1;
         prev_done_cyc = last_done_cyc;
         last_done_cyc = cyc;
         if (sb.size() == 0) begin
            tests++;
            fails++;
            $display("FAIL unexpected_done: got bin=%0d, expected no done",
                     bin_out);
         end else begin
            e = sb.pop_front();
            check("bin_out", int'(bin_out), int'(e.bin));
            check("err", int'(err), int'(e.err));
         end
      end
   end

   // Starts a conversion; returns at the negedge after the sampling edge.
   task automatic issue(input logic [15:0] v, input int eb, input bit ee,
                        input bit expect_it);
      exp_t e;
      @(negedge clk);
      start  = 1'b1;
      bcd_in = v;
      if (expect_it) begin
         e.bin = 14'(eb);
         e.err = ee;
         sb.push_back(e);
      end
      @(negedge clk);
      start = 1'b0;
   endtask

   task automatic drain(input string name);
      int n = 0;
      while (sb.size() != 0 && n < 30) begin
         @(posedge clk);
         n++;
      end
      @(negedge clk);
      if (sb.size() != 0) begin
         tests++;
         fails++;
         $display("FAIL %s_timeout: got %0d pending, expected 0", name,
                  sb.size());
         sb.delete();
      end
   endtask

   initial begin
      int d0;
      int n;

      repeat (3) @(negedge clk);
      check("rst_busy", int'(busy), 0);
      check("rst_done", int'(done), 0);
      check("rst_bin", int'(bin_out), 0);
      check("rst_err", int'(err), 0);
      rst_n = 1'b1;
      @(negedge clk);

      // 1: 9999 with busy/latency profile
      issue(16'h9999, 9999, 1'b0, 1'b1);
      for (int i = 0; i < 4; i++) begin
         check("t1_busy", int'(busy), 1);
         check("t1_nodone", int'(done), 0);
         @(negedge clk);
      end
      check("t1_busy_off", int'(busy), 0);
      check("t1_done", int'(done), 1);
      drain("t1");
      check("t1_done_pulse", int'(done), 0);

      // 2,3 and extra directed vectors
      issue(16'h0000, 0, 1'b0, 1'b1);
      drain("zero");
      issue(16'h0001, 1, 1'b0, 1'b1);
      drain("one");
      issue(16'h12A4, 1304, 1'b1, 1'b1);
      drain("bad_digit");
      issue(16'h0042, 42, 1'b0, 1'b1);
      drain("err_clear");
      issue(16'h9090, 9090, 1'b0, 1'b1);
      drain("9090");
      // 15*1111 = 16665, wraps to 281 in 14 bits
      issue(16'hFFFF, 281, 1'b1, 1'b1);
      drain("wrap");

      // 4: start while busy is ignored
      d0 = done_cnt;
      issue(16'h1234, 1234, 1'b0, 1'b1);
      @(negedge clk);
      start  = 1'b1;
      bcd_in = 16'h5555;
      @(negedge clk);
      start = 1'b0;
      drain("t4");
      repeat (10) @(negedge clk);
      check("t4_single_done", done_cnt - d0, 1);
      check("t4_bin_hold", int'(bin_out), 1234);

      // 5: reset mid-conversion
      d0 = done_cnt;
      issue(16'h8765, 0, 1'b0, 1'b0);
      @(negedge clk);
      #2 rst_n = 1'b0;
      #1;
      check("t5_rst_busy", int'(busy), 0);
      check("t5_rst_bin", int'(bin_out), 0);
      check("t5_rst_err", int'(err), 0);
      check("t5_rst_done", int'(done), 0);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      repeat (8) @(negedge clk);
      check("t5_no_done", done_cnt - d0, 0);
      issue(16'h0042, 42, 1'b0, 1'b1);
      drain("t5_after");

      // 6: back-to-back via start in done cycle
      d0 = done_cnt;
      issue(16'h1234, 1234, 1'b0, 1'b1);
      n = 0;
      while (!done && n < 20) begin
         @(negedge clk);
         n++;
      end
      check("t6_first_done_seen", int'(done), 1);
      start  = 1'b1;
      bcd_in = 16'h4321;
      begin
         exp_t e;
         e.bin = 14'd4321;
         e.err = 1'b0;
         sb.push_back(e);
      end
      @(negedge clk);
      start = 1'b0;
      drain("t6");
      check("t6_two_dones", done_cnt - d0, 2);
      check("t6_spacing", last_done_cyc - prev_done_cyc, 5);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
